// File: rtl/fb_delay_pkg.sv
// fb_delay_pkg: shared types and constants for the fb_delay_line feedback delay.
//   CH_DEF / DEPTH_DEF : default channel count and shift-register length
//   TAP_W_DEF          : tap-select width for DEPTH_DEF
//   MAJ_TAP_MAX        : highest usable tap when the 3-sample majority filter
//                        is built in (FB_DELAY_MAJORITY_EN)
//   chan_cfg_t         : per-channel {tap, inv} configuration register
//   maj3               : 2-of-3 majority helper
// chan_cfg_t is sized from DEPTH_DEF, so a different depth is selected by
// changing DEPTH_DEF here rather than overriding DEPTH on a single instance.
package fb_delay_pkg;

    localparam int CH_DEF      = 4;
    localparam int DEPTH_DEF   = 16;
    localparam int TAP_W_DEF   = $clog2(DEPTH_DEF);
    localparam int MAJ_TAP_MAX = DEPTH_DEF - 3;

    typedef struct packed {
        logic [TAP_W_DEF-1:0] tap;
        logic                 inv;
    } chan_cfg_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fb_delay_if.sv
// fb_delay_if: strobe, data and config bus of fb_delay_line.
//   en         : shift strobe
//   din        : one input bit per channel
//   cfg_we     : single-cycle config write strobe
//   cfg_ch     : target channel (values >= CH are ignored by the slave)
//   cfg_tap    : new tap for the target channel
//   cfg_inv    : new output polarity for the target channel (1 = inverted)
//   dout       : delayed, polarity-adjusted output per channel
//   dout_valid : per channel, the selected tap holds real data
// master drives the strobe/data/config side; slave is the delay line.
interface fb_delay_if #(
    parameter int CH    = 4,
    parameter int DEPTH = 16,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
);
    logic             en;
    logic [CH-1:0]    din;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [TAP_W-1:0] cfg_tap;
    logic             cfg_inv;
    logic [CH-1:0]    dout;
    logic [CH-1:0]    dout_valid;

    modport master (
        output en, din, cfg_we, cfg_ch, cfg_tap, cfg_inv,
        input  dout, dout_valid
    );

    modport slave (
        input  en, din, cfg_we, cfg_ch, cfg_tap, cfg_inv,
        output dout, dout_valid
    );
endinterface

// File: rtl/fb_delay_chan.sv
// fb_delay_chan: one channel of the feedback delay line.
//   clk, rst   : clock, synchronous active-high reset
//   en         : shift strobe, samples din into stage 0
//   din        : channel input bit
//   cfg_we     : write tap/inv of this channel and restart fill tracking
//   cfg_tap    : tap to write
//   cfg_inv    : polarity to write
//   dout       : selected tap xor inv, forced to 0 while not valid
//   dout_valid : enough strobes seen since reset/config to fill the tap
// Optional feature: FB_DELAY_MAJORITY_EN turns the output into a 2-of-3 vote
// over taps tap, tap+1, tap+2 (glitch filter), saturates written taps at
// DEPTH-3 and extends the fill requirement by the two extra stages.
module fb_delay_chan
    import fb_delay_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             cfg_we,
    input  logic [TAP_W-1:0] cfg_tap,
    input  logic             cfg_inv,
    output logic             dout,
    output logic             dout_valid
);
`ifdef FB_DELAY_MAJORITY_EN
    localparam int SPAN = 3;
`else
    localparam int SPAN = 1;
`endif
    // One spare bit so tap+SPAN never wraps.
    localparam int FILL_W = TAP_W + 1;

    logic [DEPTH-1:0]  sr;
    chan_cfg_t         cfg_q;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_max;
    logic [TAP_W-1:0]  tap_wr;
    logic              tap_bit;

`ifdef FB_DELAY_MAJORITY_EN
    localparam logic [TAP_W-1:0] TAP_SAT = TAP_W'(DEPTH - 3);
    // The vote reads two stages past the tap, so keep tap+2 inside the register.
    assign tap_wr = (cfg_tap > TAP_SAT) ? TAP_SAT : cfg_tap;
`else
    assign tap_wr = cfg_tap;
`endif

    // Strobes needed before every stage the output reads holds real data.
    assign fill_max = {1'b0, cfg_q.tap} + FILL_W'(SPAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cfg_q <= '0;
            fill  <= '0;
        end else begin
            if (en) begin
                sr <= {sr[DEPTH-2:0], din};
            end
            // A config write keeps the data but restarts fill tracking; the
            // clear wins over a simultaneous strobe.
            if (cfg_we) begin
                cfg_q.tap <= tap_wr;
                cfg_q.inv <= cfg_inv;
                fill      <= '0;
            end else if (en && (fill < fill_max)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

`ifdef FB_DELAY_MAJORITY_EN
    logic [TAP_W-1:0] tap1;
    logic [TAP_W-1:0] tap2;
    assign tap1    = cfg_q.tap + TAP_W'(1);
    assign tap2    = cfg_q.tap + TAP_W'(2);
    assign tap_bit = maj3(sr[cfg_q.tap], sr[tap1], sr[tap2]);
`else
    assign tap_bit = sr[cfg_q.tap];
`endif

    assign dout_valid = (fill >= fill_max);
    // Gate after the inversion so an inverted channel still reads 0 until valid.
    assign dout       = dout_valid & (tap_bit ^ cfg_q.inv);

endmodule

// File: rtl/fb_delay_line.sv
// fb_delay_line: multi-channel programmable delay line for the cochlea
// feedback path. Each channel is a clocked shift register with a runtime tap,
// optional output inversion and a fill-tracking valid flag.
//   clk : sole clock
//   rst : synchronous active-high reset (clears data, taps, polarity, fill)
//   bus : fb_delay_if slave (en/din strobe, cfg_* write port, dout/dout_valid)
// Outputs are combinational from registers only; config takes effect the
// cycle after cfg_we. Optional feature: FB_DELAY_MAJORITY_EN (3-sample
// majority glitch filter, see fb_delay_chan).
module fb_delay_line
    import fb_delay_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic       clk,
    input  logic       rst,
    fb_delay_if.slave  bus
);
    logic [CH-1:0] cfg_we_c;
    logic [CH-1:0] dout_c;
    logic [CH-1:0] valid_c;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        // Exact-match decode: a cfg_ch at or beyond CH selects no channel,
        // so an out-of-range write changes nothing.
        assign cfg_we_c[c] = bus.cfg_we && (bus.cfg_ch == CH_W'(c));

        fb_delay_chan #(
            .DEPTH (DEPTH),
            .TAP_W (TAP_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .din        (bus.din[c]),
            .cfg_we     (cfg_we_c[c]),
            .cfg_tap    (bus.cfg_tap),
            .cfg_inv    (bus.cfg_inv),
            .dout       (dout_c[c]),
            .dout_valid (valid_c[c])
        );
    end

    assign bus.dout       = dout_c;
    assign bus.dout_valid = valid_c;

endmodule
